// File: rtl/cam_ctrl_if.sv
// Handshake bundle between the button/vsync front end and the camera control FSM.
interface cam_ctrl_if #(
   parameter int MODE_BITS = 3
);
   logic [2:0]           btn_pulse;
   logic                 frame_start;
   logic                 frame_end;
   logic                 wr_en;
   logic                 frozen;
   logic                 capture_busy;
   logic                 capture_done;
   logic [MODE_BITS-1:0] filter_mode;

   modport master (
      output btn_pulse, frame_start, frame_end,
      input  wr_en, frozen, capture_busy, capture_done, filter_mode
   );

   modport slave (
      input  btn_pulse, frame_start, frame_end,
      output wr_en, frozen, capture_busy, capture_done, filter_mode
   );
endinterface

// File: rtl/cam_ctrl_fsm.sv
// Camera control FSM: frame-aligned one-shot capture, freeze/resume, and filter-mode select.
// Optional AUTO_RESUME_EN: leave FROZEN after HOLD_FRAMES frame_start pulses.
module cam_ctrl_fsm #(
   parameter int NUM_MODES   = 5,
   parameter int MODE_BITS   = 3,
   parameter int HOLD_FRAMES = 150,
   parameter int HOLD_BITS   = 8
) (
   input logic     clk,
   input logic     rst,
   cam_ctrl_if.slave bus
);

   localparam logic [1:0] LIVE    = 2'd0;
   localparam logic [1:0] ARM     = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] FROZEN  = 2'd3;

   localparam logic [MODE_BITS-1:0] MODE_MAX = MODE_BITS'(NUM_MODES - 1);

   function automatic logic [MODE_BITS-1:0] mode_next(input logic [MODE_BITS-1:0] m);
      return (m >= MODE_MAX) ? '0 : m + MODE_BITS'(1);
   endfunction

   function automatic logic [MODE_BITS-1:0] mode_prev(input logic [MODE_BITS-1:0] m);
      return (m == '0 || m > MODE_MAX) ? MODE_MAX : m - MODE_BITS'(1);
   endfunction

   logic [1:0]           state, state_nxt;
   logic [MODE_BITS-1:0] mode_q, mode_nxt;
   logic                 wr_en_q, frozen_q, busy_q, done_q;
   logic                 cap_btn, mode_inc, mode_dec;

   assign cap_btn  = bus.btn_pulse[0];
   assign mode_inc = bus.btn_pulse[1] & ~bus.btn_pulse[2];
   assign mode_dec = bus.btn_pulse[2] & ~bus.btn_pulse[1];

`ifdef AUTO_RESUME_EN
   localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(HOLD_FRAMES - 1);
   logic [HOLD_BITS-1:0] hold_cnt, hold_nxt;
`endif

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
`ifdef AUTO_RESUME_EN
      hold_nxt  = hold_cnt;
`endif
      case (state)
         LIVE:    if (cap_btn) state_nxt = ARM;
         // A coincident frame_end belongs to the previous frame, so frame_start alone decides.
         ARM:     if (bus.frame_start) state_nxt = CAPTURE;
         CAPTURE: if (bus.frame_end) begin
            state_nxt = FROZEN;
`ifdef AUTO_RESUME_EN
            hold_nxt  = '0;
`endif
         end
         FROZEN: begin
            if (cap_btn) state_nxt = LIVE;
`ifdef AUTO_RESUME_EN
            else if (bus.frame_start) begin
               if (hold_cnt == HOLD_LAST) state_nxt = LIVE;
               else                       hold_nxt  = hold_cnt + HOLD_BITS'(1);
            end
`endif
         end
         default: state_nxt = LIVE;
      endcase

      // Mode changes are locked out while a capture is pending or in progress.
      if (state == LIVE || state == FROZEN) begin
         if (mode_inc)      mode_nxt = mode_next(mode_q);
         else if (mode_dec) mode_nxt = mode_prev(mode_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= LIVE;
         mode_q  <= '0;
         wr_en_q <= 1'b0;
         frozen_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef AUTO_RESUME_EN
         hold_cnt <= '0;
`endif
      end else begin
         state    <= state_nxt;
         mode_q   <= mode_nxt;
         wr_en_q  <= (state_nxt != FROZEN);
         frozen_q <= (state_nxt == FROZEN);
         busy_q   <= (state_nxt == ARM) || (state_nxt == CAPTURE);
         done_q   <= (state == CAPTURE) && bus.frame_end;
`ifdef AUTO_RESUME_EN
         hold_cnt <= hold_nxt;
`endif
      end
   end

   assign bus.wr_en        = wr_en_q;
   assign bus.frozen       = frozen_q;
   assign bus.capture_busy = busy_q;
   assign bus.capture_done = done_q;
   assign bus.filter_mode  = mode_q;

endmodule

// File: tb/tb_cam_ctrl_fsm.sv
// Directed bench for cam_ctrl_fsm: reset, capture flow, mode wrap, lockouts, corner cases, hold.
module tb_cam_ctrl_fsm;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   cam_ctrl_if #(.MODE_BITS(3)) bus ();

   cam_ctrl_fsm #(
      .NUM_MODES  (5),
      .MODE_BITS  (3),
      .HOLD_FRAMES(3),
      .HOLD_BITS  (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, let the edge take them, then clear the pulses.
   task automatic step(input logic [2:0] btn, input logic fs, input logic fe);
      bus.btn_pulse   = btn;
      bus.frame_start = fs;
      bus.frame_end   = fe;
      @(posedge clk);
      #1;
      bus.btn_pulse   = 3'b000;
      bus.frame_start = 1'b0;
      bus.frame_end   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(3'b000, 1'b0, 1'b0);
   endtask

   task automatic chk_out(input string tag, input logic wr, input logic fz,
                          input logic busy, input logic done, input logic [2:0] mode);
      chk({tag, ".wr_en"},        bus.wr_en,        wr);
      chk({tag, ".frozen"},       bus.frozen,       fz);
      chk({tag, ".capture_busy"}, bus.capture_busy, busy);
      chk({tag, ".capture_done"}, bus.capture_done, done);
      chk({tag, ".filter_mode"},  bus.filter_mode,  mode);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [2:0] exp_seq [8];
      exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};

      rst = 1'b1;
      bus.btn_pulse   = 3'b000;
      bus.frame_start = 1'b0;
      bus.frame_end   = 1'b0;

      // Reset held 3 clocks, then released
      idle(3);
      chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      rst = 1'b0;
      idle(1);
      chk_out("rst_release", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Basic capture
      step(3'b001, 1'b0, 1'b0);
      chk_out("arm", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      idle(19);
      step(3'b000, 1'b1, 1'b0);
      chk_out("capture", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      idle(99);
      chk_out("capture_wait", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      step(3'b000, 1'b0, 1'b1);
      chk_out("frozen_entry", 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
      idle(1);
      chk_out("frozen_hold", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

      // Mode stepping in FROZEN
      for (int i = 0; i < 8; i++) begin
         step(3'b010, 1'b0, 1'b0);
         chk("mode_next_seq", bus.filter_mode, exp_seq[i]);
      end
      step(3'b100, 1'b0, 1'b0);
      chk("mode_prev", bus.filter_mode, 3'd2);
      step(3'b110, 1'b0, 1'b0);
      chk_out("mode_both", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

      // Resume, then capture+next together in LIVE
      step(3'b001, 1'b0, 1'b0);
      chk_out("resume", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
      step(3'b011, 1'b0, 1'b0);
      chk_out("live_cap_next", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);

      // Lockouts in ARM and CAPTURE
      step(3'b010, 1'b0, 1'b0);
      chk_out("arm_next_ign", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
      step(3'b001, 1'b0, 1'b0);
      chk_out("arm_cap_ign", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
      step(3'b000, 1'b0, 1'b1);
      chk_out("arm_fe_ign", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
      step(3'b000, 1'b1, 1'b0);
      chk_out("arm_to_cap", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
      step(3'b011, 1'b0, 1'b0);
      chk_out("cap_next_cap_ign", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
      step(3'b000, 1'b1, 1'b0);
      chk_out("cap_fs_ign", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
      step(3'b100, 1'b0, 1'b0);
      chk_out("cap_prev_ign", 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
      step(3'b000, 1'b0, 1'b1);
      chk_out("cap_done", 1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
      idle(2);
      chk_out("cap_done_once", 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);

      // frame_start and frame_end together in CAPTURE
      step(3'b001, 1'b0, 1'b0);
      step(3'b001, 1'b0, 1'b0);
      step(3'b000, 1'b1, 1'b0);
      step(3'b000, 1'b1, 1'b1);
      chk_out("cap_fs_fe", 1'b0, 1'b1, 1'b0, 1'b1, 3'd3);

      // Reset in ARM
      step(3'b001, 1'b0, 1'b0);
      step(3'b010, 1'b0, 1'b0);
      chk("live_next", bus.filter_mode, 3'd4);
      step(3'b001, 1'b0, 1'b0);
      chk_out("arm_pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, 3'd4);
      rst = 1'b1;
      idle(1);
      chk_out("arm_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      rst = 1'b0;
      idle(1);
      chk_out("arm_rst_rel", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      step(3'b000, 1'b0, 1'b1);
      chk_out("live_fe_ign", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

      // Prev wrap from 0, next wrap from top
      step(3'b100, 1'b0, 1'b0);
      chk("prev_wrap", bus.filter_mode, 3'd4);
      step(3'b010, 1'b0, 1'b0);
      chk("next_wrap", bus.filter_mode, 3'd0);

      // ARM with frame_start and frame_end together goes to CAPTURE
      step(3'b001, 1'b0, 1'b0);
      step(3'b000, 1'b1, 1'b1);
      chk_out("arm_fs_fe", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      step(3'b000, 1'b0, 1'b1);
      chk_out("arm_fs_fe_done", 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);

      // Hold frames in FROZEN
      step(3'b000, 1'b1, 1'b0);
      step(3'b000, 1'b1, 1'b0);
      chk_out("hold_2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      step(3'b000, 1'b1, 1'b0);
`ifdef AUTO_RESUME_EN
      chk_out("hold_3_resume", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
`else
      chk_out("hold_3", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 7; i++) step(3'b000, 1'b1, 1'b0);
      chk_out("hold_10", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
